// File: rtl/fakeram_dp_ctrl_pkg.sv
// fakeram_dp_ctrl_pkg: shared constants and width helpers for the fakeram dual-port controller
package fakeram_dp_ctrl_pkg;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [2:0] EMA_DEFAULT = 3'b010;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fakeram_dp_port_ctrl_if.sv
// fakeram_dp_port_ctrl_if: request/return streams plus macro pins of the dual-port controller
interface fakeram_dp_port_ctrl_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
    logic              init_done;
    logic              wr_v;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_v;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_v;
    logic              rd_data_yumi;
    logic              mem_cena;
    logic [ADDR_W-1:0] mem_aa;
    logic [DATA_W-1:0] mem_qa;
    logic              mem_cenb;
    logic [ADDR_W-1:0] mem_ab;
    logic [DATA_W-1:0] mem_db;
    logic [2:0]        mem_ema;
    modport slave (
        output init_done, wr_ready, rd_ready, rd_data, rd_data_v,
        output mem_cena, mem_aa, mem_cenb, mem_ab, mem_db, mem_ema,
        input  wr_v, wr_addr, wr_data, rd_v, rd_addr, rd_data_yumi, mem_qa
    );
    modport master (
        input  init_done, wr_ready, rd_ready, rd_data, rd_data_v,
        input  mem_cena, mem_aa, mem_cenb, mem_ab, mem_db, mem_ema,
        output wr_v, wr_addr, wr_data, rd_v, rd_addr, rd_data_yumi, mem_qa
    );
endinterface

// File: rtl/fakeram_dp_rd_fifo.sv
// fakeram_dp_rd_fifo: small read-return FIFO with valid/yumi handshake and occupancy count
module fakeram_dp_rd_fifo
    import fakeram_dp_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     yumi,
    output logic [DATA_W-1:0]        dout,
    output logic                     v,
    output logic [cnt_w(DEPTH)-1:0]  cnt
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic              pop;
    assign v    = cnt != '0;
    assign pop  = yumi & v;
    assign dout = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    // popping an empty FIFO is a consumer bug; the pop itself is ignored
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) yumi |-> v)
        else $error("rd_fifo pop while empty");
endmodule

// File: rtl/fakeram_dp_port_ctrl.sv
// fakeram_dp_port_ctrl: request-side controller for the fakeram 32x32 dual-port macro (read A, write B)
module fakeram_dp_port_ctrl
    import fakeram_dp_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int OFIFO_DEPTH = 2,
    parameter int INIT_CLEAR  = 1
) (
    input logic                    clk,
    input logic                    rst,
    fakeram_dp_port_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = cnt_w(OFIFO_DEPTH);
    logic [0:0]        state;
    logic [ADDR_W:0]   init_cnt;
    logic              inflight, fwd;
    logic [DATA_W-1:0] fwd_data;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       occ;
    logic              run, clr, pop, credit, wr_rdy, rd_rdy, wr_acc, rd_acc;
    always_comb begin
        run    = ~rst & (state == ST_RUN);
        clr    = ~rst & (state == ST_INIT);
        pop    = bus.rd_data_yumi & bus.rd_data_v;
        occ    = {1'b0, fifo_cnt} + (CW+1)'(inflight) - (CW+1)'(pop);
        credit = occ < (CW+1)'(OFIFO_DEPTH);
        wr_rdy = run & ~inflight;
        rd_rdy = run & credit & ~(bus.wr_v & inflight);
        wr_acc = bus.wr_v & wr_rdy;
        rd_acc = bus.rd_v & rd_rdy;
    end
    // QA is corrupted by a concurrent write, so writes wait out the capture cycle
    always_comb begin
        bus.init_done = run;
        bus.wr_ready  = wr_rdy;
        bus.rd_ready  = rd_rdy;
        bus.mem_cena  = ~rd_acc;
        bus.mem_aa    = rd_acc ? bus.rd_addr : '0;
        bus.mem_cenb  = ~(wr_acc | clr);
        bus.mem_ab    = clr ? init_cnt[ADDR_W-1:0] : (wr_acc ? bus.wr_addr : '0);
        bus.mem_db    = wr_acc ? bus.wr_data : '0;
        bus.mem_ema   = EMA_DEFAULT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            inflight <= 1'b0;
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == (ADDR_W+1)'(DEPTH - 1)) state <= ST_RUN;
            end
            inflight <= rd_acc;
            fwd      <= rd_acc & wr_acc & (bus.rd_addr == bus.wr_addr);
            if (rd_acc & wr_acc & (bus.rd_addr == bus.wr_addr)) fwd_data <= bus.wr_data;
        end
    end
    fakeram_dp_rd_fifo #(.DATA_W(DATA_W), .DEPTH(OFIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (fwd ? fwd_data : bus.mem_qa),
        .yumi (bus.rd_data_yumi),
        .dout (bus.rd_data),
        .v    (bus.rd_data_v),
        .cnt  (fifo_cnt)
    );
endmodule
